// File: rtl/rr_mux_feeder_4.sv
// rr_mux_feeder_4: round-robin arbiter over four valid/ready requesters that
// feeds a one-entry registered output stage, reporting the winning source
// index alongside the data (the select a downstream mux_4_1 would use).
//
// Handshake: a word moves on any edge where valid and ready are both high.
// req_ready is combinational and depends on out_ready, so the output register
// can be refilled in the same cycle it is drained. Requesters hold valid and
// data stable until they see ready.
//
// Optional feature: define RR_MUX_FEEDER_GRANT_CNT_EN to get per-source
// saturating grant counters on grant_cnt. Otherwise grant_cnt is all zeros
// and no counter flops exist.
module rr_mux_feeder_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req_valid,
  input  logic [WIDTH-1:0]   d0,
  input  logic [WIDTH-1:0]   d1,
  input  logic [WIDTH-1:0]   d2,
  input  logic [WIDTH-1:0]   d3,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready,
  output logic [4*CNT_W-1:0] grant_cnt
);

  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic             can_load;
  logic [WIDTH-1:0] win_data;

  // The output slot is free when empty or being drained this cycle.
  assign can_load = (|req_valid) && (!out_valid || out_ready);

  // Pick the first valid requester starting from ptr; scanning offsets from
  // the far end down lets the nearest one win.
  always_comb begin
    logic [1:0] idx;
    grant = 2'd0;
    idx   = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req_valid[idx]) grant = idx;
    end
  end

  // One-hot ready to the winner, only when the slot can take the word.
  always_comb begin
    req_ready = 4'b0000;
    if (can_load) req_ready[grant] = 1'b1;
  end

  // Internal 4:1 data mux on the winner.
  always_comb begin
    win_data = d0;
    case (grant)
      2'd0: win_data = d0;
      2'd1: win_data = d1;
      2'd2: win_data = d2;
      2'd3: win_data = d3;
      default: win_data = d0;
    endcase
  end

  // Output register: load on grant, clear valid when drained with no refill.
  // Data and source hold their last values once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
    end else if (can_load) begin
      out_valid <= 1'b1;
      out_data  <= win_data;
      out_src   <= grant;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Priority rotates only on a grant; idle and stalled cycles leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
    end else if (can_load) begin
      ptr <= grant + 2'd1;
    end
  end

`ifdef RR_MUX_FEEDER_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [4];

  // Saturating per-source grant counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_ready[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Pack counters, source i at [i*CNT_W +: CNT_W].
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < 4; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_mux_feeder_4.sv
// Directed bench for rr_mux_feeder_4: expected words are queued when a grant
// is issued and checked by a monitor when the output stage is consumed.
module tb_rr_mux_feeder_4;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [3:0]         req_valid = 4'b0000;
  logic [WIDTH-1:0]   d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic [3:0]         req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready = 1'b0;
  logic [4*CNT_W-1:0] grant_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH+1:0] exp_q[$];

  rr_mux_feeder_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .grant_cnt(grant_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs applied just after a rising edge, req_ready
  // checked at the falling edge, expected word queued when a grant is due.
  task automatic step(input logic [3:0] rv, input logic ordy, input logic [3:0] exp_rr,
                      input logic [1:0] es, input logic [WIDTH-1:0] ed);
    req_valid = rv;
    out_ready = ordy;
    @(negedge clk);
    chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
    if (exp_rr != 4'b0000) exp_q.push_back({es, ed});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d);
    chk({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, "_src"}, {30'd0, out_src}, {30'd0, s});
    chk({name, "_data"}, {28'd0, out_data}, {28'd0, d});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got src=%0d data=%0h, queue empty", out_src, out_data);
      end else begin
        chk("word", {26'd0, out_src, out_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    // reset then idle
    @(negedge clk);
    chk_out("reset", 1'b0, 2'd0, 4'h0);
    chk("reset_rr", {28'd0, req_ready}, 32'd0);
    chk("reset_cnt", {24'd0, grant_cnt}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    chk_out("idle", 1'b0, 2'd0, 4'h0);

    // single requester 2
    d2 = 4'hA;
    step(4'b0100, 1'b1, 4'b0100, 2'd2, 4'hA);
    chk_out("single", 1'b1, 2'd2, 4'hA);
    // ptr is now 3: requester 3 wins with all valid
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    step(4'b1111, 1'b1, 4'b1000, 2'd3, 4'h4);
    // round robin continues 0,1,2,3,0
    step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'h1);
    step(4'b1111, 1'b1, 4'b0010, 2'd1, 4'h2);
    step(4'b1111, 1'b1, 4'b0100, 2'd2, 4'h3);
    step(4'b1111, 1'b1, 4'b1000, 2'd3, 4'h4);
    step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'h1);

    // back-pressure: load d1=5, stall 3 cycles
    d1 = 4'h5;
    step(4'b1111, 1'b1, 4'b0010, 2'd1, 4'h5);
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b0, 4'b0000, 2'd0, 4'h0);
      chk_out("stall", 1'b1, 2'd1, 4'h5);
    end
    step(4'b1111, 1'b1, 4'b0100, 2'd2, 4'h3);
    chk_out("after_stall", 1'b1, 2'd2, 4'h3);

    // drain: valid drops, data and source hold
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    chk_out("drain", 1'b0, 2'd2, 4'h3);

    // reset mid-transfer (ptr=3, only requester 1 valid)
    step(4'b0010, 1'b1, 4'b0010, 2'd1, 4'h5);
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 2'd0, 4'h0);
    exp_q.delete();
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    step(4'b1111, 1'b1, 4'b0001, 2'd0, 4'h1);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);

    // counters: fresh reset, requester 0 granted 5 times
    rst = 1'b1;
    #2;
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      step(4'b0001, 1'b1, 4'b0001, 2'd0, 4'h1);
`ifdef RR_MUX_FEEDER_GRANT_CNT_EN
      chk("cnt0", {30'd0, grant_cnt[1:0]}, (i < 3) ? i + 1 : 3);
      chk("cnt_others", {26'd0, grant_cnt[7:2]}, 32'd0);
`else
      chk("cnt_off", {24'd0, grant_cnt}, 32'd0);
`endif
    end
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);
    step(4'b0000, 1'b1, 4'b0000, 2'd0, 4'h0);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL leftover: got %0d unconsumed words, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
